logic_gate_scheduler: RTL

- Shares one bitwise logic-gate datapath (AND / OR / NOT) among NREQ requesters.
- Uses round-robin arbitration, a request/grant handshake and a registered result with a valid pulse.
- Sits between several client blocks and the gate datapath, so one gate unit serves the whole design.
- Each accepted operation is latched, executed, returned and released in a fixed 3-state sequence.

---
 rtl/logic_gate_scheduler_pkg.sv | 15 +
 rtl/logic_gate_scheduler_rr_arbiter.sv | 41 ++++
 rtl/logic_gate_scheduler.sv | 125 ++++++++++++
 3 files changed

// File: rtl/logic_gate_scheduler_pkg.sv
// Shared op codes and FSM state encoding for logic_gate_scheduler.
package logic_gate_scheduler_pkg;

    localparam logic [1:0] OP_AND = 2'b00;
    localparam logic [1:0] OP_OR  = 2'b01;
    localparam logic [1:0] OP_NOT = 2'b10;
    localparam logic [1:0] OP_RSV = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_EXEC = 2'b01,
        S_RESP = 2'b10
    } state_t;

endpackage

// File: rtl/logic_gate_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: first set request at or after ptr, wrapping modulo NREQ.
module rr_arbiter
    import logic_gate_scheduler_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int ID_W = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [ID_W-1:0] ptr,
    output logic [NREQ-1:0] gnt,
    output logic [ID_W-1:0] idx
);

    localparam logic [ID_W:0] NREQ_W = (ID_W+1)'(NREQ);

    logic [ID_W:0]   sum;
    logic [ID_W-1:0] pos;
    logic            found;

    always_comb begin
        gnt   = '0;
        idx   = '0;
        sum   = '0;
        pos   = '0;
        found = 1'b0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            // one extra bit lets ptr+i exceed NREQ-1 before the wrap subtraction
            sum = {1'b0, ptr} + (ID_W+1)'(i);
            if (sum >= NREQ_W) begin
                sum = sum - NREQ_W;
            end
            pos = sum[ID_W-1:0];
            if (!found && req[pos]) begin
                found    = 1'b1;
                gnt[pos] = 1'b1;
                idx      = pos;
            end
        end
    end

endmodule

// File: rtl/logic_gate_scheduler.sv
// Round-robin shared AND/OR/NOT gate unit with grant handshake and registered result.
// Define LOGIC_SCHED_XOR_EN to turn op code 11 into XOR instead of a reserved/error op.
module logic_gate_scheduler
    import logic_gate_scheduler_pkg::*;
#(
    parameter int NREQ  = 4,
    parameter int ID_W  = 2,
    parameter int WIDTH = 8
) (
    input  logic                  iClk,
    input  logic                  iRst,
    input  logic [NREQ-1:0]       iReq,
    input  logic [2*NREQ-1:0]     iOpSel,
    input  logic [WIDTH*NREQ-1:0] iA,
    input  logic [WIDTH*NREQ-1:0] iB,
    output logic [NREQ-1:0]       oGnt,
    output logic                  oBusy,
    output logic                  oValid,
    output logic [ID_W-1:0]       oId,
    output logic [WIDTH-1:0]      oResult,
    output logic                  oErr
);

    state_t           state;
    logic [ID_W-1:0]  ptr;
    logic [ID_W-1:0]  ptr_next;
    logic [NREQ-1:0]  arb_gnt;
    logic [ID_W-1:0]  arb_idx;
    logic [1:0]       sel_op;
    logic [WIDTH-1:0] sel_a;
    logic [WIDTH-1:0] sel_b;
    logic [1:0]       op_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] gate_res;
    logic             gate_err;

    rr_arbiter #(
        .NREQ (NREQ),
        .ID_W (ID_W)
    ) u_arb (
        .req (iReq),
        .ptr (ptr),
        .gnt (arb_gnt),
        .idx (arb_idx)
    );

    // operand mux keyed by the one-hot grant
    always_comb begin
        sel_op = '0;
        sel_a  = '0;
        sel_b  = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (arb_gnt[i]) begin
                sel_op = iOpSel[2*i +: 2];
                sel_a  = iA[WIDTH*i +: WIDTH];
                sel_b  = iB[WIDTH*i +: WIDTH];
            end
        end
    end

    always_comb begin
        gate_res = '0;
        gate_err = 1'b0;
        case (op_q)
            OP_AND:  gate_res = a_q & b_q;
            OP_OR:   gate_res = a_q | b_q;
            OP_NOT:  gate_res = ~a_q;
            default: begin
`ifdef LOGIC_SCHED_XOR_EN
                gate_res = a_q ^ b_q;
`else
                gate_err = 1'b1;
`endif
            end
        endcase
    end

    assign ptr_next = (oId == ID_W'(NREQ-1)) ? '0 : oId + ID_W'(1);

    always_ff @(posedge iClk) begin
        if (iRst) begin
            state   <= S_IDLE;
            ptr     <= '0;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            oGnt    <= '0;
            oBusy   <= 1'b0;
            oValid  <= 1'b0;
            oId     <= '0;
            oResult <= '0;
            oErr    <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (|iReq) begin
                        op_q  <= sel_op;
                        a_q   <= sel_a;
                        b_q   <= sel_b;
                        oGnt  <= arb_gnt;
                        oId   <= arb_idx;
                        oBusy <= 1'b1;
                        state <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    oResult <= gate_res;
                    oErr    <= gate_err;
                    oValid  <= 1'b1;
                    state   <= S_RESP;
                end
                S_RESP: begin
                    oValid <= 1'b0;
                    oGnt   <= '0;
                    oBusy  <= 1'b0;
                    ptr    <= ptr_next;
                    state  <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
